fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage sitting directly upstream of imem: owns the 64-bit PC,
//   drives imem_pc, captures the combinational imem_instr in the same cycle, and
//   queues {pc, instr} pairs in a DEPTH-entry FIFO toward decode (valid/ready).
//   Handles control-flow redirects (flush + new PC) and flags misaligned targets.
// PARAMETERS
//   RESET_PC  64'h0  PC loaded on reset
//   DEPTH     4      FIFO entries (power of two, >=2)
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   asynchronous active-low reset
//   fetch_en       in   1   1 = fetching permitted this cycle
//   redirect_valid in   1   branch/jump/trap redirect request
//   redirect_pc    in   64  redirect target
//   imem_pc        out  64  address to imem (= current PC register)
//   imem_instr     in   32  instruction from imem, valid same cycle as imem_pc
//   out_valid      out  1   FIFO head valid toward decode
//   out_ready      in   1   decode accepts head
//   out_pc         out  64  PC of head instruction
//   out_instr      out  32  head instruction word
//   fetch_fault    out  1   sticky: last redirect target was misaligned
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0),
//     out_valid=0, out_pc=0, out_instr=0 (when empty, data outputs read 0), fetch_fault=0.
//   imem_pc = pc register, combinational; no other logic on that path.
//   pop  = out_valid & out_ready.
//   push = fetch_en & ~fetch_fault & ~redirect_valid & (count<DEPTH | pop).
//   On push: FIFO[wr] <= {pc, imem_instr}; wr++; pc <= pc+4 (64-bit, wraps
//     2^64-4 -> 0 silently).
//   On pop: rd++. Simultaneous push+pop: count unchanged; allowed when full.
//   count = count + push - pop; ptrs wrap mod DEPTH.
//   Redirect (highest priority, any state):
//     - FIFO flushed: count=0, rd=wr=0; a same-cycle pop is discarded, no push.
//     - redirect_pc[1:0]==0: pc<=redirect_pc, fetch_fault<=0.
//     - redirect_pc[1:0]!=0: pc<=redirect_pc, fetch_fault<=1; pushes blocked
//       until next aligned redirect (fault clears only by redirect or reset).
//   Latency: redirect at edge N -> imem_pc=target after N; first push at edge
//     N+1 (if fetch_en, ~fault); out_valid=1 after N+1 (2 cycles redirect->decode).
//   Steady state with out_ready=1, fetch_en=1: one instruction per cycle, PCs
//     consecutive +4, no bubbles; FIFO holds 1 entry.
//   out_ready=0: FIFO fills to DEPTH, then pc holds, imem_pc stable; no overwrite.
//   fetch_en=0: pc and FIFO writes frozen; pops continue.
//   out_valid/out_pc/out_instr driven from FIFO head registers only (no
//     combinational path from imem_instr to outputs).
//   Reset asserted mid-operation: immediate clear to reset values, in-flight
//     entries lost; first push on first edge after rst_n rises.
// TESTING
//   1 reset, fetch_en=1, out_ready=1, imem returns pc>>2 -> out_pc 0,4,8,...
//     out_instr 0,1,2,... one per cycle starting cycle 2.
//   2 out_ready=0 for 10 cycles -> count saturates at 4, imem_pc holds 0x10;
//     release -> PCs 0x0..0x1C delivered in order, none lost or duplicated.
//   3 redirect_valid with redirect_pc=0x200 while FIFO holds 3 -> out_valid=0
//     next cycle, next delivered out_pc=0x200, then 0x204.
//   4 redirect_pc=0x202 -> fetch_fault=1, no pushes; then redirect 0x300 ->
//     fetch_fault=0, out_pc=0x300 two cycles later.
//   5 redirect to 64'hFFFF_FFFF_FFFF_FFFC -> next out_pc 0 (wrap); rst_n pulse
//     mid-stream -> out_valid=0 asynchronously, restart at RESET_PC.
//   6 full FIFO with simultaneous pop and push -> count stays 4, order preserved.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses imem and queues {pc, instr}
// pairs toward decode through a small valid/ready FIFO, with flush-on-redirect.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fetch_fault
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [63:0]   pc_r;
   logic          fault_r;
   logic [AW-1:0] rd_r;
   logic [AW-1:0] wr_r;
   logic [AW:0]   count_r;
   logic [63:0]   mem_pc_r    [DEPTH];
   logic [31:0]   mem_instr_r [DEPTH];

   logic          empty_s;
   logic          pop_s;
   logic          push_s;

   // Handshake qualification; a full FIFO still accepts a push when the head leaves.
   always_comb begin
      empty_s = 1'b1;
      pop_s   = 1'b0;
      push_s  = 1'b0;
      if (count_r != '0) begin
         empty_s = 1'b0;
      end else begin
         empty_s = 1'b1;
      end
      pop_s  = ~empty_s & out_ready;
      push_s = fetch_en & ~fault_r & ~redirect_valid & ((count_r != DEPTH_C) | pop_s);
   end

   // PC register and misaligned-target fault flag; redirect wins over sequential fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r    <= RESET_PC;
         fault_r <= 1'b0;
      end else if (redirect_valid) begin
         pc_r    <= redirect_pc;
         fault_r <= (redirect_pc[1:0] != 2'b00);
      end else if (push_s) begin
         pc_r    <= pc_r + 64'd4;
      end
   end

   // FIFO pointers and occupancy; a redirect discards everything, including a same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_r    <= '0;
         wr_r    <= '0;
         count_r <= '0;
      end else if (redirect_valid) begin
         rd_r    <= '0;
         wr_r    <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            wr_r <= wr_r + AW'(1);
         end
         if (pop_s) begin
            rd_r <= rd_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage, written with the PC and the instruction imem returns for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_r[i]    <= 64'h0;
            mem_instr_r[i] <= 32'h0;
         end
      end else if (push_s) begin
         mem_pc_r[wr_r]    <= pc_r;
         mem_instr_r[wr_r] <= imem_instr;
      end
   end

   // Outputs come only from registers; data reads zero while the FIFO is empty.
   always_comb begin
      imem_pc     = pc_r;
      fetch_fault = fault_r;
      out_valid   = ~empty_s;
      out_pc      = 64'h0;
      out_instr   = 32'h0;
      if (!empty_s) begin
         out_pc    = mem_pc_r[rd_r];
         out_instr = mem_instr_r[rd_r];
      end else begin
         out_pc    = 64'h0;
         out_instr = 32'h0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; imem returns pc>>2 as the instruction.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] imem_pc;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        fetch_fault;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(64'h0), .DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   assign imem_instr = imem_pc[33:2];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      #12;
      check_eq("rst_valid", {63'h0, out_valid}, 64'h0);
      check_eq("rst_pc", out_pc, 64'h0);
      check_eq("rst_instr", {32'h0, out_instr}, 64'h0);
      check_eq("rst_imem_pc", imem_pc, 64'h0);
      check_eq("rst_fault", {63'h0, fetch_fault}, 64'h0);
      rst_n     = 1'b1;
      fetch_en  = 1'b1;
      out_ready = 1'b1;

      // Streaming: one instruction per cycle, consecutive PCs.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t1_valid", {63'h0, out_valid}, 64'h1);
         check_eq("t1_pc", out_pc, 64'(4 * i));
         check_eq("t1_instr", {32'h0, out_instr}, 64'(i));
      end

      // Backpressure: fill to DEPTH, PC stalls at 0x10, then drain in order.
      tick();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_eq("t2_hold_pc", imem_pc, 64'h10);
      check_eq("t2_head_pc", out_pc, 64'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_eq("t2_pc", out_pc, 64'(4 * i));
         check_eq("t2_instr", {32'h0, out_instr}, 64'(i));
         tick();
         if (i == 0) check_eq("t6_push_when_full", imem_pc, 64'h14);
      end
      check_eq("t6_head", out_pc, 64'h20);
      check_eq("t6_pc", imem_pc, 64'h30);

      // Pops continue with fetch_en low; leaves 3 entries, then redirect flushes.
      fetch_en = 1'b0;
      tick();
      check_eq("fe0_pc_frozen", imem_pc, 64'h30);
      check_eq("fe0_head", out_pc, 64'h24);
      fetch_en       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      tick();
      redirect_valid = 1'b0;
      check_eq("t3_flush_valid", {63'h0, out_valid}, 64'h0);
      check_eq("t3_imem_pc", imem_pc, 64'h200);
      tick();
      check_eq("t3_valid", {63'h0, out_valid}, 64'h1);
      check_eq("t3_pc0", out_pc, 64'h200);
      check_eq("t3_instr0", {32'h0, out_instr}, 64'h80);
      tick();
      check_eq("t3_pc1", out_pc, 64'h204);

      // Misaligned redirect: sticky fault blocks pushes until an aligned redirect.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h202;
      tick();
      redirect_valid = 1'b0;
      check_eq("t4_fault", {63'h0, fetch_fault}, 64'h1);
      for (int i = 0; i < 3; i++) tick();
      check_eq("t4_no_push_valid", {63'h0, out_valid}, 64'h0);
      check_eq("t4_pc_held", imem_pc, 64'h202);
      check_eq("t4_fault_sticky", {63'h0, fetch_fault}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h300;
      tick();
      redirect_valid = 1'b0;
      check_eq("t4_fault_clr", {63'h0, fetch_fault}, 64'h0);
      check_eq("t4_gap_valid", {63'h0, out_valid}, 64'h0);
      tick();
      check_eq("t4_pc", out_pc, 64'h300);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      check_eq("t5_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("t5_top_instr", {32'h0, out_instr}, 64'hFFFF_FFFF);
      tick();
      check_eq("t5_wrap_pc", out_pc, 64'h0);
      check_eq("t5_wrap_imem", imem_pc, 64'h4);

      // Asynchronous reset mid-stream, then restart from RESET_PC.
      rst_n = 1'b0;
      #1;
      check_eq("t5_async_valid", {63'h0, out_valid}, 64'h0);
      check_eq("t5_async_pc", imem_pc, 64'h0);
      #1;
      rst_n = 1'b1;
      tick();
      check_eq("t5_restart_valid", {63'h0, out_valid}, 64'h1);
      check_eq("t5_restart_pc0", out_pc, 64'h0);
      tick();
      check_eq("t5_restart_pc1", out_pc, 64'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
